// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide,
// one step per clock over WIDTH cycles, launched by start and reported by done.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_UDIV  = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nx;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_prod;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_dbz;

    logic             w_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg;
    logic             w_div0;
    logic [WIDTH:0]   w_add;
    logic [PW-1:0]    w_mul_next;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [PW-1:0]    w_div_next;
    logic [PW-1:0]    w_fix;

    // Operand conditioning for PREP: magnitudes and product sign for SMULL
    assign w_signed = (r_op == OP_SMULL);
    assign w_a_mag  = (w_signed && r_a[WIDTH-1]) ? WIDTH'(-r_a) : r_a;
    assign w_b_mag  = (w_signed && r_b[WIDTH-1]) ? WIDTH'(-r_b) : r_b;
    assign w_neg    = w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_div0   = (r_op == OP_UDIV) && (r_b == '0);

    // Shift-add step: multiplier sits in the low half and shifts out as the sum shifts in
    assign w_add      = r_prod[0] ? ({1'b0, r_prod[PW-1:WIDTH]} + {1'b0, r_a})
                                  : {1'b0, r_prod[PW-1:WIDTH]};
    assign w_mul_next = {w_add, r_prod[WIDTH-1:1]};

    // Restoring step: remainder in the high half, dividend/quotient in the low half
    assign w_rem_sh   = r_prod[PW-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {r_prod[PW-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

    // Final sign correction of the full double-width product
    assign w_fix = r_neg ? PW'(-r_prod) : r_prod;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_PREP;
            S_PREP:  w_state_nx = w_div0 ? S_DONE : S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nx = S_FIX;
            S_FIX:   w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != S_IDLE);
            r_done <= (w_state_nx == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= OP_MUL;
            r_a    <= '0;
            r_b    <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_prod <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= a;
                        r_b   <= b;
                        r_dbz <= 1'b0;
                    end
                end
                S_PREP: begin
                    r_a    <= w_a_mag;
                    r_neg  <= w_neg;
                    r_cnt  <= CNT_W'(WIDTH - 1);
                    r_prod <= (r_op == OP_UDIV) ? {{WIDTH{1'b0}}, r_a}
                                                : {{WIDTH{1'b0}}, w_b_mag};
                    if (w_div0) begin
                        r_lo  <= '1;
                        r_hi  <= r_a;
                        r_dbz <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt  <= r_cnt - CNT_W'(1);
                    r_prod <= (r_op == OP_UDIV) ? w_div_next : w_mul_next;
                end
                S_FIX: begin
                    r_lo <= w_fix[WIDTH-1:0];
                    r_hi <= w_fix[PW-1:WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result_lo   = r_lo;
    assign result_hi   = r_hi;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_UDIV  = 2'b11;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one start pulse; returns at the negedge of the first cycle after acceptance
    task automatic launch(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
        @(negedge clk);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; checks latency, busy throughout, and done/busy fall after
    task automatic wait_done(input string tag, input int exp_lat);
        int   n;
        logic busy_ok;
        n       = 1;
        busy_ok = busy;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            busy_ok = busy_ok & busy;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk({tag, "_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int n_done;
        int first;
        int second;
        int seen;

        reset = 1'b1;
        start = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lo", 64'(result_lo), 64'd0);
        chk("rst_hi", 64'(result_hi), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);

        // (2^32-1)^2 = 2^64 - 2^33 + 1
        launch(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("umull", 35);
        chk("umull_hi", 64'(result_hi), 64'hFFFF_FFFE);
        chk("umull_lo", 64'(result_lo), 64'h0000_0001);

        // -2 * 3 = -6
        launch(OP_SMULL, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("smull", 35);
        chk("smull_hi", 64'(result_hi), 64'hFFFF_FFFF);
        chk("smull_lo", 64'(result_lo), 64'hFFFF_FFFA);

        // (-2^31)^2 = 2^62
        launch(OP_SMULL, 32'h8000_0000, 32'h8000_0000);
        wait_done("smin", 35);
        chk("smin_hi", 64'(result_hi), 64'h4000_0000);
        chk("smin_lo", 64'(result_lo), 64'h0000_0000);

        // 100 = 7*14 + 2
        launch(OP_UDIV, 32'd100, 32'd7);
        wait_done("udiv", 35);
        chk("udiv_q", 64'(result_lo), 64'd14);
        chk("udiv_r", 64'(result_hi), 64'd2);
        chk("udiv_dbz", 64'(div_by_zero), 64'd0);

        launch(OP_UDIV, 32'd5, 32'd0);
        wait_done("div0", 2);
        chk("div0_lo", 64'(result_lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(result_hi), 64'd5);
        chk("div0_dbz", 64'(div_by_zero), 64'd1);

        // start held high: (2^16+3)(2*2^16+5) = 2^33 + 0xB0000 + 0xF; then 7*9 = 63
        @(negedge clk);
        start  = 1'b1;
        op     = OP_MUL;
        a      = 32'h0001_0003;
        b      = 32'h0002_0005;
        n_done = 0;
        first  = 0;
        second = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) chk("dbz_clr", 64'(div_by_zero), 64'd0);
            if (c == 10) begin
                a = 32'd7;
                b = 32'd9;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first = c;
                    chk("mul_lo", 64'(result_lo), 64'h000B_000F);
                    chk("mul_hi", 64'(result_hi), 64'h0000_0002);
                end else if (n_done == 2) begin
                    second = c;
                    chk("mul2_lo", 64'(result_lo), 64'd63);
                end
            end
        end
        start = 1'b0;
        chk("cont_cnt", 64'(n_done), 64'd2);
        chk("cont_first", 64'(first), 64'd35);
        chk("cont_space", 64'(second - first), 64'd36);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("cont_drain", 64'(seen), 64'd1);

        // Reset during RUN cycle 10
        launch(OP_UMULL, 32'hFFFF_FFFF, 32'd2);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_lo", 64'(result_lo), 64'd0);
        chk("abort_hi", 64'(result_hi), 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_nodone", 64'(seen), 64'd0);

        launch(OP_UMULL, 32'd3, 32'd4);
        wait_done("post", 35);
        chk("post_lo", 64'(result_lo), 64'd12);
        chk("post_hi", 64'(result_hi), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
